perf_counter_bank: RTL
======================

# perf_counter_bank

Synthesizable, parametrised performance-counter bank that moves processor event accounting out of the bench and into hardware. It counts N independent single-bit event channels plus a free-running cycle counter, freezes all counts when a halt is signalled, and exposes a snapshot/readout port. It sits beside the processor core. Typical channels are retired instructions, I-cache requests and hits, and D-cache requests and hits.

## Interface
- `NUM_CH`, default 5: number of event channels, 1..32.
- `CNT_W`, default 32: width of every counter, including the cycle counter, 8..64.
- `SATURATE`, default 0: 1 = counters stick at all-ones; 0 = counters wrap to 0.
- `SEL_W`, default `$clog2(NUM_CH+1)`: width of `rd_sel`.

Ports:
- `clk`  in  1  processor clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global count enable. When 0, nothing counts, but control inputs still act.
- `event`  in  NUM_CH  per-channel event strobe, sampled at `posedge clk`.
- `halt`  in  1  halt strobe from the pipeline.
- `clear`  in  1  zero all live counters and overflow flags, and leave FROZEN.
- `snap`  in  1  copy live counters into the shadow registers.
- `rd_sel`  in  SEL_W  shadow select. 0..NUM_CH-1 = channels; NUM_CH = cycle counter.
- `rd_data`  out  CNT_W  combinational mux of the shadow register selected by `rd_sel`.
- `ovf`  out  NUM_CH+1  sticky overflow flags. Bit NUM_CH belongs to the cycle counter.
- `frozen`  out  1  high while in state FROZEN.

## Operation
- The block has two states, RUN and FROZEN. Reset enters RUN.
- Behaviour in RUN, on a cycle with `en`=1:
  - The cycle counter increments by 1.
  - Each channel i with `event[i]`=1 increments by 1.
  - All increments happen in parallel; any combination of channels may fire in the same cycle.
- Halt handling (`halt`=1 in RUN):
  - Events and the cycle increment of that same cycle are counted, so the halt cycle is inclusive.
  - The state becomes FROZEN after that edge.
  - `halt` is ignored while already in FROZEN, and when `en`=0.
- In FROZEN, all live counters hold. Only `clear` or `rst` returns the block to RUN.
- `clear` (any state):
  - Next edge: all live counters = 0, all `ovf` bits = 0, state = RUN.
  - Events, `halt` and increments in the `clear` cycle are discarded. `clear` beats `halt`.
  - Shadow registers are not affected by `clear`.
- `snap`:
  - Each shadow register takes the live counter value present before the edge. Increments of the `snap` cycle are excluded.
  - `snap` works in both states and regardless of `en`.
  - If `snap` and `clear` are asserted together, the shadows capture the pre-clear values.
- Overflow, when a counter at all-ones is incremented:
  - `SATURATE`=1: the counter stays at all-ones.
  - `SATURATE`=0: the counter wraps to 0.
  - In both modes, the matching `ovf` bit is set and held until `clear` or `rst`.
- Readout:
  - `rd_sel` from 0 to NUM_CH returns the matching shadow.
  - `rd_sel` > NUM_CH returns 0.
- Counters are unsigned; an increment is always +1, with no carry into a neighbouring channel.

## Timing
- Reset values: all live counters, shadows and `ovf` bits = 0; `frozen` = 0; `rd_data` = 0.
- An `event` or `en` change at edge k is reflected in the live counters after edge k. It becomes visible on `rd_data` only after a `snap` at edge k+1 or later.
- `frozen` rises one cycle after the `halt` edge, and falls one cycle after the `clear` edge.
- `snap` to `rd_data`: 1 cycle, registered shadow. `rd_sel` to `rd_data`: 0 cycles, combinational.
- `rst` mid-operation overrides every other input on that edge.

## Test plan
- Reset, then 10 cycles with `en`=1 and `event`=5'b00001, then `snap`, `rd_sel`=0 → `rd_data`=10; `rd_sel`=5 → `rd_data`=10; `rd_sel`=6 → `rd_data`=0.
- `en`=1 with `event[2]` toggling 1,0,1,1, then `halt` on the cycle after the last event, with `event[2]`=1 on the `halt` cycle → channel 2 = 4; `frozen`=1 the next cycle. 20 more `event`s are then ignored; `snap` reads 4.
- `CNT_W`=8, `SATURATE`=0, 257 events on channel 1 → count = 1, `ovf[1]`=1. With `SATURATE`=1 → count = 255, `ovf[1]`=1.
- `clear` and `halt` in the same cycle while in RUN, with all events = 1 → all counters = 0, `frozen`=0, `ovf`=0.
- `snap` and `clear` in the same cycle with channel 0 = 7 → shadow 0 = 7 and live counter = 0. The next `snap` after 3 events returns 3.
- `en`=0 for 5 cycles with all events = 1, then `snap` → all shadows = 0. `rst` asserted mid-count in FROZEN → `frozen`=0 and all outputs = 0 the next cycle.

Source files
------------

// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - control, event and readout bundle for perf_counter_bank
// The master drives events and controls; the slave (the counter bank) returns readout and status.
interface perf_counter_bank_if #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = $clog2(NUM_CH + 1)
);
  logic              en;
  logic [NUM_CH-1:0] evt;
  logic              halt;
  logic              clear;
  logic              snap;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH:0]   ovf;
  logic              frozen;

  modport master (
    output en, evt, halt, clear, snap, rd_sel,
    input  rd_data, ovf, frozen
  );

  modport slave (
    input  en, evt, halt, clear, snap, rd_sel,
    output rd_data, ovf, frozen
  );
endinterface

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - N event counters plus a cycle counter with halt freeze and shadow readout
// Index NUM_CH of every per-counter array is the free-running cycle counter.
module perf_counter_bank #(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0,
  parameter int SEL_W    = $clog2(NUM_CH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  perf_counter_bank_if.slave  bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_count_en;
  logic             w_frozen;
  logic [NUM_CH:0]  w_inc;
  logic [CNT_W-1:0] r_cnt    [NUM_CH+1];
  logic [CNT_W-1:0] r_shadow [NUM_CH+1];
  logic [NUM_CH:0]  r_ovf;
  logic [CNT_W-1:0] w_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // clear wins over halt and discards that cycle's increments
  always_comb begin
    w_state_nxt = r_state;
    w_count_en  = 1'b0;
    w_frozen    = (r_state == ST_FROZEN);
    if (bus.clear) begin
      w_state_nxt = ST_RUN;
    end else if ((r_state == ST_RUN) && bus.en) begin
      w_count_en = 1'b1;
      if (bus.halt) begin
        w_state_nxt = ST_FROZEN;
      end
    end
  end

  assign w_inc = {1'b1, bus.evt} & {(NUM_CH + 1){w_count_en}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i <= NUM_CH; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i <= NUM_CH; i++) begin
        if (bus.snap) begin
          r_shadow[i] <= r_cnt[i];
        end
        if (bus.clear) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_inc[i]) begin
          if (&r_cnt[i]) begin
            r_ovf[i] <= 1'b1;
            if (SATURATE == 0) begin
              r_cnt[i] <= '0;
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // selects beyond the cycle counter read as zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i <= NUM_CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        w_rd_data = r_shadow[i];
      end
    end
  end

  assign bus.rd_data = w_rd_data;
  assign bus.ovf     = r_ovf;
  assign bus.frozen  = w_frozen;

endmodule
